// File: rtl/round_pack_mult_pkg.sv
// Shared floating-point definitions for the multiplier round/pack stage:
// default widths, exponent/NaN constants and the output status-flag record.
package round_pack_mult_pkg;

    localparam int unsigned FP_SIG_WIDTH = 23;
    localparam int unsigned FP_EX_WIDTH  = 8;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    typedef enum logic [2:0] {
        PACK_NAN,
        PACK_INF,
        PACK_ZERO,
        PACK_UFL,
        PACK_OFL,
        PACK_NORM
    } pack_sel_e;

    function automatic int unsigned exp_bias(input int unsigned ex_w);
        return (32'd1 << (ex_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned exp_max(input int unsigned ex_w);
        return (32'd1 << ex_w) - 32'd1;
    endfunction

    function automatic int unsigned qnan_frac(input int unsigned sig_w);
        return 32'd1 << (sig_w - 1);
    endfunction

endpackage

// File: rtl/round_pack_mult_hca.sv
// Han-Carlson parallel-prefix adder: sum = a + b + cin, with carry out.
// Odd bit positions run a Kogge-Stone tree; even positions take one final merge.
module round_pack_mult_hca #(
    parameter int unsigned width = 24
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    logic [width-1:0] p;
    logic [width-1:0] g;
    logic [width-1:0] gg;
    logic [width-1:0] pp;

    always_comb begin
        p     = a ^ b;
        g     = a & b;
        g[0]  = g[0] | (p[0] & cin);
        gg    = g;
        pp    = p;
        // Descending walk so each level reads the previous level's values in place.
        for (int unsigned d = 1; d < width; d = d * 2) begin
            for (int unsigned i = width - 1; i >= 1; i--) begin
                if ((i % 2) == 1 && i >= d) begin
                    gg[i] = gg[i] | (pp[i] & gg[i-d]);
                    pp[i] = pp[i] & pp[i-d];
                end
            end
        end
        for (int unsigned i = 2; i < width; i += 2) begin
            gg[i] = gg[i] | (pp[i] & gg[i-1]);
        end
        sum  = p ^ {gg[width-2:0], cin};
        cout = gg[width-1];
    end

endmodule

// File: rtl/round_pack_mult.sv
// Two-stage round-to-nearest-even and IEEE-754 pack stage behind the multiplier
// normaliser, with valid/ready flow control on both sides.
module round_pack_mult
    import round_pack_mult_pkg::*;
#(
    parameter int unsigned sig_width = FP_SIG_WIDTH,
    parameter int unsigned ex_width  = FP_EX_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sign,
    input  logic [sig_width-1:0]          in_mant,
    input  logic                          in_guard,
    input  logic                          in_sticky,
    input  logic [ex_width+1:0]           in_exp,
    input  logic                          in_is_nan,
    input  logic                          in_is_inf,
    input  logic                          in_is_zero,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ex_width+sig_width:0]   out_result,
    output logic                          out_overflow,
    output logic                          out_underflow,
    output logic                          out_inexact
);

    localparam logic signed [ex_width+1:0] EXP_MAX_S = (ex_width + 2)'(exp_max(ex_width));
    localparam logic [sig_width-1:0]       QNAN_FRAC = (sig_width)'(qnan_frac(sig_width));
    localparam logic [ex_width-1:0]        EXP_ONES  = '1;

    logic s1_adv;
    logic s2_adv;

    logic                        s1_valid;
    logic                        s1_sign;
    logic [sig_width-1:0]        s1_frac;
    logic signed [ex_width+1:0]  s1_exp;
    logic                        s1_inexact;
    logic                        s1_nan;
    logic                        s1_inf;
    logic                        s1_zero;

    logic                        s2_valid;
    logic [ex_width+sig_width:0] s2_result;
    fp_flags_t                   s2_flags;

    logic                        round_up;
    logic [sig_width:0]          mant_r;
    logic                        mant_cout_unused;
    logic                        mant_carry;
    logic [ex_width+1:0]         exp_r;
    logic                        exp_cout_unused;

    pack_sel_e                   pack_sel;
    logic [ex_width+sig_width:0] pack_result;
    fp_flags_t                   pack_flags;

    assign s2_adv   = ~s2_valid | out_ready;
    assign s1_adv   = ~s1_valid | s2_adv;
    assign in_ready = s1_adv;

    assign round_up   = in_guard & (in_sticky | in_mant[0]);
    assign mant_carry = mant_r[sig_width];

    round_pack_mult_hca #(
        .width (sig_width + 1)
    ) u_mant_inc (
        .a    ({1'b0, in_mant}),
        .b    ('0),
        .cin  (round_up),
        .sum  (mant_r),
        .cout (mant_cout_unused)
    );

    round_pack_mult_hca #(
        .width (ex_width + 2)
    ) u_exp_inc (
        .a    (in_exp),
        .b    ('0),
        .cin  (mant_carry),
        .sum  (exp_r),
        .cout (exp_cout_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_frac    <= '0;
            s1_exp     <= '0;
            s1_inexact <= 1'b0;
            s1_nan     <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_frac    <= mant_r[sig_width-1:0];
                s1_exp     <= exp_r;
                s1_inexact <= in_guard | in_sticky;
                s1_nan     <= in_is_nan;
                s1_inf     <= in_is_inf;
                s1_zero    <= in_is_zero;
            end
        end
    end

    always_comb begin
        pack_sel = PACK_NORM;
        if (s1_nan)                   pack_sel = PACK_NAN;
        else if (s1_inf)              pack_sel = PACK_INF;
        else if (s1_zero)             pack_sel = PACK_ZERO;
        else if (s1_exp <= 0)         pack_sel = PACK_UFL;
        else if (s1_exp >= EXP_MAX_S) pack_sel = PACK_OFL;
    end

    always_comb begin
        pack_result        = {s1_sign, s1_exp[ex_width-1:0], s1_frac};
        pack_flags         = '0;
        pack_flags.inexact = s1_inexact;
        case (pack_sel)
            PACK_NAN: begin
                pack_result = {1'b0, EXP_ONES, QNAN_FRAC};
                pack_flags  = '0;
            end
            PACK_INF: begin
                pack_result = {s1_sign, EXP_ONES, {sig_width{1'b0}}};
                pack_flags  = '0;
            end
            PACK_ZERO: begin
                pack_result = {s1_sign, {(ex_width + sig_width){1'b0}}};
                pack_flags  = '0;
            end
            PACK_UFL: begin
                pack_result          = {s1_sign, {(ex_width + sig_width){1'b0}}};
                pack_flags.underflow = 1'b1;
                pack_flags.inexact   = 1'b1;
            end
            PACK_OFL: begin
                pack_result         = {s1_sign, EXP_ONES, {sig_width{1'b0}}};
                pack_flags.overflow = 1'b1;
                pack_flags.inexact  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= pack_result;
                s2_flags  <= pack_flags;
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_result    = s2_result;
    assign out_overflow  = s2_flags.overflow;
    assign out_underflow = s2_flags.underflow;
    assign out_inexact   = s2_flags.inexact;

endmodule
